// File: rtl/test_status_device.sv
// Memory-mapped test-status responder: TOHOST verdict, pass/fail counters, cycle watchdog.
// Zero-wait-state accept (req_ready = sel); read data registered, 1-cycle latency; never backpressures.
module test_status_device #(
    parameter logic [31:0] BASE_ADDR      = 32'hF000_0000,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             done,
    output logic             passed,
    output logic             timed_out,
    output logic [30:0]      fail_code,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             bus_err
);

    typedef enum logic {RUN, DONE} state_t;

    localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic [31:0]       tohost;
    logic [31:0]       rd_dat;
    logic [1:0]        offs;
    logic              sel, in_run, wr_full, wr_ok, rd_acc;
    logic              tohost_wr, term_wr, wd_exp;

    assign sel       = req_valid && (req_addr[31:4] == BASE_ADDR[31:4]);
    // Held low during reset so every output reads 0 while rst_n is asserted.
    assign req_ready = sel && rst_n;
    assign offs      = req_addr[3:2];
    assign in_run    = (state == RUN);
    assign done      = (state == DONE);
    assign wr_full   = (req_wstrb == 4'hF);
    assign wr_ok     = sel && req_we && wr_full && in_run;
    assign rd_acc    = sel && !req_we;
    assign tohost_wr = wr_ok && (offs == 2'd0) && (req_wdata != 32'h0);
    assign term_wr   = tohost_wr && req_wdata[0];
    assign wd_exp    = in_run && (wd_cnt == WD_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (term_wr || wd_exp) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        rd_dat = 32'h0;
        case (offs)
            2'd0: rd_dat = tohost;
            2'd1: rd_dat = 32'(pass_count);
            2'd2: rd_dat = 32'(fail_count);
            2'd3: rd_dat = {28'b0, bus_err, timed_out, passed, done};
            default: rd_dat = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt     <= '0;
            tohost     <= 32'h0;
            passed     <= 1'b0;
            timed_out  <= 1'b0;
            fail_code  <= 31'h0;
            pass_count <= '0;
            fail_count <= '0;
            bus_err    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
        end else begin
            rsp_valid <= rd_acc;
            rsp_rdata <= rd_acc ? rd_dat : 32'h0;

            if (in_run && !wd_exp) wd_cnt <= wd_cnt + 1'b1;
            if (tohost_wr) tohost <= req_wdata;

            // A terminating write in the expiry cycle takes precedence over the watchdog.
            if (term_wr) begin
                passed    <= (req_wdata == 32'h1);
                fail_code <= req_wdata[31:1];
                timed_out <= 1'b0;
            end else if (wd_exp) begin
                passed    <= 1'b0;
                fail_code <= 31'h0;
                timed_out <= 1'b1;
            end

            if (wr_ok && offs == 2'd1 && pass_count != {CNT_W{1'b1}})
                pass_count <= pass_count + 1'b1;
            if (wr_ok && offs == 2'd2 && fail_count != {CNT_W{1'b1}})
                fail_count <= fail_count + 1'b1;

            if (sel && req_we && !wr_full && in_run) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_test_status_device.sv
// Directed bench for test_status_device: a default instance and a short-watchdog, 2-bit-counter instance.
module tb_test_status_device;

    localparam logic [31:0] TOHOST   = 32'hF000_0000;
    localparam logic [31:0] PASS_INC = 32'hF000_0004;
    localparam logic [31:0] FAIL_INC = 32'hF000_0008;
    localparam logic [31:0] STATUS   = 32'hF000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;

    logic        req_ready_a, rsp_valid_a, done_a, passed_a, timed_out_a, bus_err_a;
    logic [31:0] rsp_rdata_a;
    logic [30:0] fail_code_a;
    logic [15:0] pass_count_a, fail_count_a;

    logic        req_ready_b, rsp_valid_b, done_b, passed_b, timed_out_b, bus_err_b;
    logic [31:0] rsp_rdata_b;
    logic [30:0] fail_code_b;
    logic [1:0]  pass_count_b, fail_count_b;

    logic        rdy_a, vld_a;
    logic [31:0] rd_a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    test_status_device dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
        .done(done_a), .passed(passed_a), .timed_out(timed_out_a), .fail_code(fail_code_a),
        .pass_count(pass_count_a), .fail_count(fail_count_a), .bus_err(bus_err_a)
    );

    test_status_device #(.TIMEOUT_CYCLES(20), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .done(done_b), .passed(passed_b), .timed_out(timed_out_b), .fail_code(fail_code_b),
        .pass_count(pass_count_b), .fail_count(fail_count_b), .bus_err(bus_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; one request accepted at the next rising edge, returns at the following falling edge.
    task automatic bus_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        #1 rdy_a = req_ready_a;
        @(negedge clk);
        vld_a = rsp_valid_a;
        rd_a  = rsp_rdata_a;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_req(1'b1, addr, data, 4'hF);
    endtask

    task automatic rd(input logic [31:0] addr);
        bus_req(1'b0, addr, 32'h0, 4'h0);
    endtask

    // Returns at the falling edge right after release, with no rising edge seen since release.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_done", done_a, 0);
        check("rst_passed", passed_a, 0);
        check("rst_timed_out", timed_out_a, 0);
        check("rst_fail_code", fail_code_a, 0);
        check("rst_pass_count", pass_count_a, 0);
        check("rst_rsp_valid", rsp_valid_a, 0);
        check("rst_bus_err", bus_err_a, 0);

        // Passing verdict, then STATUS read
        wr(TOHOST, 32'h1);
        check("pass_ready", rdy_a, 1);
        check("pass_done", done_a, 1);
        check("pass_passed", passed_a, 1);
        check("pass_fail_code", fail_code_a, 0);
        check("pass_timed_out", timed_out_a, 0);
        rd(STATUS);
        check("status_rsp_valid", vld_a, 1);
        check("status_rdata", rd_a, 32'h3);
        @(negedge clk);
        check("idle_rsp_valid", rsp_valid_a, 0);
        check("idle_rdata", rsp_rdata_a, 0);

        // Failing verdict is terminal
        do_reset();
        wr(TOHOST, 32'h7);
        check("fail_done", done_a, 1);
        check("fail_passed", passed_a, 0);
        check("fail_code", fail_code_a, 3);
        wr(TOHOST, 32'h1);
        check("frozen_passed", passed_a, 0);
        check("frozen_code", fail_code_a, 3);
        rd(TOHOST);
        check("frozen_tohost", rd_a, 32'h7);

        // Counters, non-terminating TOHOST, saturation on the 2-bit instance
        do_reset();
        repeat (3) wr(PASS_INC, 32'hDEAD_BEEF);
        repeat (2) wr(FAIL_INC, 32'h0);
        rd(PASS_INC);
        check("rd_pass_count", rd_a, 3);
        rd(FAIL_INC);
        check("rd_fail_count", rd_a, 2);
        check("cnt_done", done_a, 0);
        wr(TOHOST, 32'h2);
        wr(TOHOST, 32'h0);
        rd(TOHOST);
        check("tohost_shadow", rd_a, 32'h2);
        check("even_done", done_a, 0);
        repeat (2) wr(PASS_INC, 32'h1);
        check("pass_count_a", pass_count_a, 5);
        check("pass_count_sat", pass_count_b, 3);
        check("fail_count_b", fail_count_b, 2);

        // Watchdog expiry 20 cycles after release
        do_reset();
        repeat (19) @(negedge clk);
        check("wd_before_done", done_b, 0);
        @(negedge clk);
        check("wd_done", done_b, 1);
        check("wd_timed_out", timed_out_b, 1);
        check("wd_passed", passed_b, 0);
        check("wd_fail_code", fail_code_b, 0);

        // Terminating write in the expiry cycle wins
        do_reset();
        repeat (19) @(negedge clk);
        wr(TOHOST, 32'h5);
        check("race_done", done_b, 1);
        check("race_timed_out", timed_out_b, 0);
        check("race_passed", passed_b, 0);
        check("race_fail_code", fail_code_b, 2);

        // Partial strobe and out-of-window requests
        do_reset();
        bus_req(1'b1, TOHOST, 32'h1, 4'h3);
        check("partial_ready", rdy_a, 1);
        check("partial_bus_err", bus_err_a, 1);
        check("partial_done", done_a, 0);
        bus_req(1'b1, 32'hF000_0010, 32'h1, 4'hF);
        check("oow_ready", rdy_a, 0);
        check("oow_done", done_a, 0);
        rd(32'hF000_0010);
        check("oow_rsp_valid", vld_a, 0);
        rd(STATUS);
        check("status_bus_err", rd_a, 32'h8);

        // Asynchronous reset while done, then watchdog restarts from zero
        wr(TOHOST, 32'h1);
        check("pre_rst_done", done_a, 1);
        rst_n = 1'b0;
        #1;
        check("async_done", done_a, 0);
        check("async_passed", passed_a, 0);
        check("async_bus_err", bus_err_a, 0);
        check("async_done_b", done_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (19) @(negedge clk);
        check("wd2_before_done", done_b, 0);
        @(negedge clk);
        check("wd2_timed_out", timed_out_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/test_status_device.md
Name: test_status_device

Overview:
- Memory-mapped responder on the CPU data bus that the test program itself writes to, reporting test progress and the final verdict.
- Benches learn pass/fail from this device instead of peeking into `regfile.registers`.
- Sits beside data memory inside the cpu top level and claims one 16-byte window.
- Adds a cycle watchdog so that a hung program still terminates the run.

Parameters:
- BASE_ADDR, 32'hF000_0000, window base; must be 16-byte aligned.
- TIMEOUT_CYCLES, 1000, number of RUN-state cycles before a forced timeout; legal range ≥ 2.
- CNT_W, 16, width of the pass and fail counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU bus request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_wstrb  input  4  byte enables.
- req_ready  output  1  request accepted this cycle.
- rsp_valid  output  1  read data valid.
- rsp_rdata  output  32  read data.
- done  output  1  test finished (sticky).
- passed  output  1  verdict; valid only when done=1.
- timed_out  output  1  the watchdog ended the test.
- fail_code  output  31  code from the failing TOHOST write.
- pass_count  output  CNT_W  PASS_INC writes counted.
- fail_count  output  CNT_W  FAIL_INC writes counted.
- bus_err  output  1  sticky: a partial-strobe write hit the window.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs go to 0.
  - The state machine goes to RUN.
  - The watchdog counter and the TOHOST shadow go to 0.
  - Reset asserted mid-test discards the verdict immediately.
- Address decode:
  - sel = req_valid && (req_addr[31:4] == BASE_ADDR[31:4]).
  - req_ready = sel, combinational; zero wait states.
  - Offset = req_addr[3:2]; req_addr[1:0] is ignored.
  - Out-of-window requests are neither acked nor acted upon.
- Register map:
  - 0x0 TOHOST: write as defined below; read returns the last accepted TOHOST value.
  - 0x4 PASS_INC: write (any data) increments pass_count; read returns pass_count zero-extended.
  - 0x8 FAIL_INC: write (any data) increments fail_count; read returns fail_count zero-extended.
  - 0xC STATUS: read only, {28'b0, bus_err, timed_out, passed, done}; writes are acked and ignored.
- Writes:
  - Take effect only when req_wstrb == 4'hF.
  - Any other strobe value is acked, discarded, and sets bus_err.
- Reads:
  - Data is registered: rsp_valid is pulsed 1 cycle after an accepted read, with rsp_rdata captured at acceptance.
  - rsp_rdata is 0 whenever rsp_valid = 0.
  - Back-to-back reads give back-to-back responses.
- TOHOST write semantics, applied in RUN only:
  - data == 0: ignored, shadow unchanged.
  - data[0] == 0 and data != 0: shadow updated, no state change.
  - data[0] == 1: shadow updated; go to DONE; done=1; passed = (data == 32'h1); fail_code = data[31:1].
- State machine:
  - RUN → DONE on a terminating TOHOST write.
  - RUN → DONE on watchdog expiry: done=1, timed_out=1, passed=0, fail_code=0.
  - DONE is terminal until reset.
- Watchdog:
  - Counts every cycle in RUN.
  - Expires on the cycle the count equals TIMEOUT_CYCLES−1.
  - Frozen in DONE.
- Simultaneous terminating TOHOST write and watchdog expiry in the same cycle: the write wins and timed_out=0.
- In DONE:
  - All writes are acked and have no effect; counters, verdict and shadow are frozen, and bus_err does not set.
  - Reads still respond.
- Counters saturate at all-ones, with no wrap-around.
- A FAIL_INC write does not end the test; it only counts.

Test Plan:
- Reset, then write 32'h1 to 0xF000_0000 → next cycle done=1, passed=1, fail_code=0, timed_out=0; read STATUS → rsp_valid one cycle later with rdata = 32'h3.
- Write 32'h7 to TOHOST → done=1, passed=0, fail_code=3; a later write of 32'h1 does not change the verdict.
- 3 PASS_INC writes and 2 FAIL_INC writes, then read 0x4 and 0x8 → rdata 3 and 2, done=0; with CNT_W=2, 5 PASS_INC writes → pass_count stays 3.
- No TOHOST write, TIMEOUT_CYCLES=20 → done=1 and timed_out=1 exactly 20 cycles after reset release; a terminating write landing on the expiry cycle → timed_out=0, verdict taken from the write.
- Write with wstrb=4'h3 to TOHOST (data 1) → req_ready=1, bus_err=1, done=0; request to 0xF000_0010 → req_ready=0, no state change.
- Assert rst_n low mid-test while done=1 → all outputs 0 immediately, without waiting for a clk edge; watchdog restarts from 0 after release.
